// File: rtl/puzzle2_pkg.sv
// Shared types for the invalid-ID range scheduler: range record and FSM states.
package puzzle2_pkg;

  localparam int ID_W = 64;

  typedef struct packed {
    logic [ID_W-1:0] id1;
    logic [ID_W-1:0] id2;
  } range_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    SUM,
    DONE
  } sched_state_e;

endpackage

// File: rtl/range_fifo.sv
// Small synchronous FIFO of ranges; head is visible combinationally while not empty.
module range_fifo
  import puzzle2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  range_t push_data,
  input  logic   pop,
  output range_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  range_t          mem [DEPTH];
  logic   [AW:0]   wr_ptr;
  logic   [AW:0]   rd_ptr;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/range_dispatch_sched.sv
// Buffers ID ranges, hands them round-robin to idle summing workers, then
// adds the workers' running sums into one total once the list has drained.
module range_dispatch_sched
  import puzzle2_pkg::*;
#(
  parameter int NUM_WORKERS = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int ID_W        = puzzle2_pkg::ID_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ID_W-1:0]             in_id1,
  input  logic [ID_W-1:0]             in_id2,
  input  logic                        in_last,
  output logic [NUM_WORKERS-1:0]      w_wr_en,
  output logic [ID_W-1:0]             w_id1,
  output logic [ID_W-1:0]             w_id2,
  input  logic [NUM_WORKERS-1:0]      w_valid,
  input  logic [NUM_WORKERS*ID_W-1:0] w_sum,
  output logic                        done,
  output logic [ID_W-1:0]             total,
  output logic [31:0]                 range_count,
  output logic [15:0]                 swap_count
);

  localparam int RR_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

  sched_state_e           state, state_next;
  range_t                 push_data, head;
  logic                   full, empty, accept, swap, grant, found, last_seen, sum_last;
  logic [NUM_WORKERS-1:0] busy, blank, eligible, grant_vec, busy_next;
  logic [RR_W-1:0]        rr, rr_next, pick, idx, sum_idx;

  assign in_ready = !reset && (state == IDLE || state == RUN) && !full && !last_seen;
  assign accept   = in_valid && in_ready;
  assign swap     = in_id1 > in_id2;
  assign eligible = ~busy & w_valid;
  assign sum_last = (int'(sum_idx) == NUM_WORKERS - 1);

  always_comb begin
    push_data.id1 = swap ? in_id2 : in_id1;
    push_data.id2 = swap ? in_id1 : in_id2;
  end

  range_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (grant),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // First eligible worker at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int j = 0; j < NUM_WORKERS; j++) begin
      idx = RR_W'((int'(rr) + j) % NUM_WORKERS);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    grant     = found && (state == RUN) && !empty;
    grant_vec = grant ? (NUM_WORKERS'(1) << pick) : '0;
    rr_next   = (int'(pick) == NUM_WORKERS - 1) ? '0 : pick + RR_W'(1);
  end

  // blank hides the worker's stale valid during the cycle the start pulse is in flight.
  assign busy_next = (busy & ~(w_valid & ~blank)) | grant_vec;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_seen && empty) state_next = DRAIN;
      DRAIN:   if (busy == '0) state_next = SUM;
      SUM:     if (sum_last) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= '0;
      blank       <= '0;
      rr          <= '0;
      last_seen   <= 1'b0;
      w_wr_en     <= '0;
      w_id1       <= '0;
      w_id2       <= '0;
      range_count <= '0;
      swap_count  <= '0;
      sum_idx     <= '0;
      total       <= '0;
      done        <= 1'b0;
    end else begin
      state   <= state_next;
      busy    <= busy_next;
      blank   <= grant_vec;
      w_wr_en <= grant_vec;
      if (accept && in_last) last_seen <= 1'b1;
      if (accept && swap && swap_count != '1) swap_count <= swap_count + 16'd1;
      if (grant) begin
        rr          <= rr_next;
        w_id1       <= head.id1;
        w_id2       <= head.id2;
        range_count <= range_count + 32'd1;
      end
      if (state == SUM) begin
        total   <= total + w_sum[int'(sum_idx)*ID_W +: ID_W];
        sum_idx <= sum_idx + RR_W'(1);
        if (sum_last) done <= 1'b1;
      end
    end
  end

endmodule
